// File: rtl/frame_pkg.sv
// frame_pkg: shared frame geometry defaults, coordinate/pixel types and
// the arbiter state encoding used by frame_arbiter and its clear counter.
package frame_pkg;

    localparam int unsigned FRAME_W_DEFAULT = 640;
    localparam int unsigned FRAME_H_DEFAULT = 480;
    localparam int unsigned COORD_X_W       = 10;
    localparam int unsigned COORD_Y_W       = 9;
    localparam int unsigned PIXEL_W         = 3;

    typedef logic [COORD_X_W-1:0] coord_x_t;
    typedef logic [COORD_Y_W-1:0] coord_y_t;
    typedef logic [PIXEL_W-1:0]   pixel_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // True when (x, y) lies inside a w x h frame.
    function automatic logic in_frame(input coord_x_t x, input coord_y_t y,
                                      input int unsigned w, input int unsigned h);
        return (32'(x) < w) && (32'(y) < h);
    endfunction

endpackage

// File: rtl/frame_clear_counter.sv
// frame_clear_counter: raster x/y position for the clear sweep.
// x runs 0..FRAME_W-1 inside y 0..FRAME_H-1; advances only when en=1.
module frame_clear_counter
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
    parameter int unsigned FRAME_H = FRAME_H_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     restart,
    input  logic     en,
    output coord_x_t x,
    output coord_y_t y,
    output logic     last
);

    localparam coord_x_t X_MAX = coord_x_t'(FRAME_W - 1);
    localparam coord_y_t Y_MAX = coord_y_t'(FRAME_H - 1);

    logic x_wrap;

    // End-of-line and last-pixel flags from the current position.
    always_comb begin
        x_wrap = (x == X_MAX);
        last   = x_wrap && (y == Y_MAX);
    end

    // Raster advance with wrap back to (0,0) after the last pixel.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_wrap) begin
                x <= '0;
                y <= last ? '0 : y + coord_y_t'(1);
            end else begin
                x <= x + coord_x_t'(1);
            end
        end
    end

endmodule

// File: rtl/frame_arbiter.sv
// frame_arbiter: single-port frame memory arbiter.
// Priority per cycle: scanout read > clear sweep > pixel write.
// All memory-side outputs are registered; read data returns 1+RD_LAT cycles
// after the accepting cycle.
// Optional build macro FRAME_ARBITER_CLIP_EN: out-of-frame pixel writes are
// accepted by the handshake but never reach memory.
module frame_arbiter
    import frame_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEFAULT,
    parameter int unsigned FRAME_H = FRAME_H_DEFAULT,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    input  logic [PIXEL_W-1:0]   clear_color,
    output logic                 clear_busy,
    output logic                 clear_done,
    input  logic                 wr_valid,
    input  logic [COORD_X_W-1:0] wr_x,
    input  logic [COORD_Y_W-1:0] wr_y,
    input  logic [PIXEL_W-1:0]   wr_data,
    output logic                 wr_ready,
    input  logic                 rd_valid,
    input  logic [COORD_X_W-1:0] rd_x,
    input  logic [COORD_Y_W-1:0] rd_y,
    output logic                 rd_data_valid,
    output logic [PIXEL_W-1:0]   rd_data,
    output logic                 mem_write_enable,
    output logic [COORD_X_W-1:0] mem_write_width,
    output logic [COORD_Y_W-1:0] mem_write_height,
    output logic [PIXEL_W-1:0]   mem_write_data,
    output logic [COORD_X_W-1:0] mem_read_width,
    output logic [COORD_Y_W-1:0] mem_read_height,
    input  logic [PIXEL_W-1:0]   mem_read_data
);

    arb_state_t      state;
    pixel_t          clear_color_q;
    coord_x_t        clr_x;
    coord_y_t        clr_y;
    logic            clr_last;
    logic            clr_step;
    logic            clr_start;
    logic            wr_fire;
    logic            wr_keep;
    logic [RD_LAT:0] rd_pipe;

    // Handshake and grant decisions for the current cycle.
    always_comb begin
        wr_ready  = !rst && !rd_valid && (state == IDLE);
        wr_fire   = wr_valid && wr_ready;
        clr_step  = (state == CLEAR) && !rd_valid;
        clr_start = (state == IDLE) && clear_req;
`ifdef FRAME_ARBITER_CLIP_EN
        wr_keep   = in_frame(wr_x, wr_y, FRAME_W, FRAME_H);
`else
        wr_keep   = 1'b1;
`endif
    end

    frame_clear_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H)
    ) u_clear_counter (
        .clk     (clk),
        .rst     (rst),
        .restart (clr_start),
        .en      (clr_step),
        .x       (clr_x),
        .y       (clr_y),
        .last    (clr_last)
    );

    // Read-valid delay line; bit RD_LAT lines up with returning memory data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:0], rd_valid};
        end
    end

    always_comb begin
        rd_data_valid = rd_pipe[RD_LAT];
        rd_data       = mem_read_data;
    end

    // Arbiter FSM with registered memory-side and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            clear_busy       <= 1'b0;
            clear_done       <= 1'b0;
            clear_color_q    <= '0;
            mem_write_enable <= 1'b0;
            mem_write_width  <= '0;
            mem_write_height <= '0;
            mem_write_data   <= '0;
            mem_read_width   <= '0;
            mem_read_height  <= '0;
        end else begin
            clear_done       <= 1'b0;
            mem_write_enable <= 1'b0;
            if (rd_valid) begin
                mem_read_width  <= rd_x;
                mem_read_height <= rd_y;
            end
            case (state)
                IDLE: begin
                    if (wr_fire && wr_keep) begin
                        mem_write_enable <= 1'b1;
                        mem_write_width  <= wr_x;
                        mem_write_height <= wr_y;
                        mem_write_data   <= wr_data;
                    end
                    if (clear_req) begin
                        state         <= CLEAR;
                        clear_busy    <= 1'b1;
                        clear_color_q <= clear_color;
                    end
                end
                CLEAR: begin
                    if (clr_step) begin
                        mem_write_enable <= 1'b1;
                        mem_write_width  <= clr_x;
                        mem_write_height <= clr_y;
                        mem_write_data   <= clear_color_q;
                        if (clr_last) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_arbiter.sv
// tb_frame_arbiter: scoreboard bench for frame_arbiter on a reduced frame.
// Stimulus pushes expected memory writes / read returns into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_frame_arbiter;

    localparam int W          = 16;
    localparam int H          = 8;
    localparam int TB_RD_LAT  = 1;
`ifdef FRAME_ARBITER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, clear_req, clear_busy, clear_done;
    logic [2:0] clear_color;
    logic       wr_valid, wr_ready;
    logic [9:0] wr_x;
    logic [8:0] wr_y;
    logic [2:0] wr_data;
    logic       rd_valid, rd_data_valid;
    logic [9:0] rd_x;
    logic [8:0] rd_y;
    logic [2:0] rd_data;
    logic       mem_write_enable;
    logic [9:0] mem_write_width, mem_read_width;
    logic [8:0] mem_write_height, mem_read_height;
    logic [2:0] mem_write_data, mem_read_data;

    frame_arbiter #(
        .FRAME_W (W),
        .FRAME_H (H),
        .RD_LAT  (TB_RD_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .clear_req        (clear_req),
        .clear_color      (clear_color),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done),
        .wr_valid         (wr_valid),
        .wr_x             (wr_x),
        .wr_y             (wr_y),
        .wr_data          (wr_data),
        .wr_ready         (wr_ready),
        .rd_valid         (rd_valid),
        .rd_x             (rd_x),
        .rd_y             (rd_y),
        .rd_data_valid    (rd_data_valid),
        .rd_data          (rd_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_width  (mem_write_width),
        .mem_write_height (mem_write_height),
        .mem_write_data   (mem_write_data),
        .mem_read_width   (mem_read_width),
        .mem_read_height  (mem_read_height),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory with TB_RD_LAT cycles of read latency.
    logic [2:0] fmem [int];
    logic [2:0] mrd_pipe [TB_RD_LAT];
    always @(posedge clk) begin : mem_model
        int ka;
        if (mem_write_enable)
            fmem[int'(mem_write_height) * 1024 + int'(mem_write_width)] = mem_write_data;
        ka = int'(mem_read_height) * 1024 + int'(mem_read_width);
        for (int i = TB_RD_LAT - 1; i > 0; i--) mrd_pipe[i] <= mrd_pipe[i-1];
        mrd_pipe[0] <= fmem.exists(ka) ? fmem[ka] : 3'd0;
    end
    assign mem_read_data = mrd_pipe[TB_RD_LAT-1];

    typedef struct { int due; int x; int y; int d; } ev_t;
    ev_t wq[$];
    ev_t rq[$];

    int checks = 0;
    int failures = 0;

    // Reference model state: clear progress as a linear pixel index.
    int smem [int];
    bit m_clear = 0;
    bit m_done = 0;
    bit m_zero = 0;
    int m_p = 0;
    int m_col = 0;

    bit mon_en = 0;
    bit exp_ready, exp_busy, exp_done, exp_zero;

    int s_rx, s_ry, s_wx, s_wy, s_wd, s_cc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int shadow_rd(input int x, input int y);
        int k = y * 1024 + x;
        return smem.exists(k) ? smem[k] : 0;
    endfunction

    // One clock cycle of stimulus plus the reference model's reaction.
    task automatic step(input bit r, input bit rv, input bit wv, input bit cr);
        ev_t e;
        @(posedge clk);
        #2;
        rst = r; rd_valid = rv; rd_x = s_rx[9:0]; rd_y = s_ry[8:0];
        wr_valid = wv; wr_x = s_wx[9:0]; wr_y = s_wy[8:0]; wr_data = s_wd[2:0];
        clear_req = cr; clear_color = s_cc[2:0];
        exp_busy  = m_clear;
        exp_done  = m_done;
        exp_zero  = m_zero;
        exp_ready = !r && !rv && !m_clear;
        m_done = 0;
        m_zero = 0;
        if (r) begin
            m_clear = 0;
            m_zero  = 1;
            while (rq.size() > 0 && rq[rq.size()-1].due > cyc) void'(rq.pop_back());
        end else begin
            if (rv) begin
                e = '{cyc + 1 + TB_RD_LAT, s_rx, s_ry, shadow_rd(s_rx, s_ry)};
                rq.push_back(e);
            end
            if (m_clear) begin
                if (!rv) begin
                    e = '{cyc + 1, m_p % W, m_p / W, m_col};
                    wq.push_back(e);
                    smem[e.y * 1024 + e.x] = m_col;
                    m_p++;
                    if (m_p == W * H) begin
                        m_clear = 0;
                        m_done  = 1;
                    end
                end
            end else begin
                if (wv && exp_ready && (!CLIP || (s_wx < W && s_wy < H))) begin
                    e = '{cyc + 1, s_wx, s_wy, s_wd};
                    wq.push_back(e);
                    smem[s_wy * 1024 + s_wx] = s_wd;
                end
                if (cr) begin
                    m_clear = 1;
                    m_p     = 0;
                    m_col   = s_cc;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        s_rx = 0; s_ry = 0; s_wx = 0; s_wy = 0; s_wd = 0; s_cc = 0;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Monitor: status every cycle, memory writes and read returns on demand.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            chk("wr_ready", int'(wr_ready), int'(exp_ready));
            chk("clear_busy", int'(clear_busy), int'(exp_busy));
            chk("clear_done", int'(clear_done), int'(exp_done));
            if (exp_zero) begin
                chk("rst_wr_addr", int'(mem_write_width) + int'(mem_write_height), 0);
                chk("rst_wr_data", int'(mem_write_data), 0);
                chk("rst_rd_addr", int'(mem_read_width) + int'(mem_read_height), 0);
            end
            if (mem_write_enable) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = wq.pop_front();
                    chk("write_cycle", cyc, e.due);
                    chk("write_x", int'(mem_write_width), e.x);
                    chk("write_y", int'(mem_write_height), e.y);
                    chk("write_data", int'(mem_write_data), e.d);
                end
            end else if (wq.size() > 0 && wq[0].due <= cyc) begin
                e = wq.pop_front();
                chk("missing_write", 0, 1);
            end
            if (rd_data_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    e = rq.pop_front();
                    chk("read_cycle", cyc, e.due);
                    chk("read_data", int'(rd_data), e.d);
                end
            end else if (rq.size() > 0 && rq[0].due <= cyc) begin
                e = rq.pop_front();
                chk("missing_rd_valid", 0, 1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1; clear_req = 0; clear_color = 0; wr_valid = 0; wr_x = 0; wr_y = 0;
        wr_data = 0; rd_valid = 0; rd_x = 0; rd_y = 0;
        s_rx = 0; s_ry = 0; s_wx = 0; s_wy = 0; s_wd = 0; s_cc = 0;
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        mon_en = 1;
        step(1, 0, 0, 0);
        idle(2);

        // Single pixel write, no reads.
        s_wx = 5; s_wy = 7; s_wd = 3;
        step(0, 0, 1, 0);
        idle(2);

        // Reads and a pending write together for 4 cycles, then the write lands.
        s_wx = 9; s_wy = 2; s_wd = 5;
        for (int i = 0; i < 4; i++) begin
            s_rx = (i == 0) ? 5 : i; s_ry = (i == 0) ? 7 : 1;
            step(0, 1, 1, 0);
        end
        step(0, 0, 1, 0);
        idle(1);
        s_rx = 9; s_ry = 2;
        step(0, 1, 0, 0);
        idle(3);

        // Full clear to color 6 with no reads.
        s_cc = 6;
        step(0, 0, 0, 1);
        s_cc = 0;
        while (m_clear) step(0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            s_rx = (i * 5) % W; s_ry = i % H;
            step(0, 1, 0, 0);
        end
        idle(3);

        // Clear with a read every 4th cycle and a write pending throughout.
        s_cc = 2;
        step(0, 0, 0, 1);
        for (int i = 0; m_clear && i < 4 * W * H; i++) begin
            s_rx = $urandom_range(W - 1); s_ry = $urandom_range(H - 1);
            s_wx = 1; s_wy = 1; s_wd = 7; s_cc = 4;
            step(0, (i % 4) == 3, 1, 1);
        end
        idle(3);

        // Reset in the middle of a clear, with a read in flight.
        s_cc = 5;
        step(0, 0, 0, 1);
        s_cc = 0;
        while (m_clear && m_p != 3 * W + 10) step(0, 0, 0, 0);
        s_rx = 3; s_ry = 3;
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        idle(2);
        s_cc = 1;
        step(0, 0, 0, 1);
        s_cc = 0;
        while (m_clear) step(0, 0, 0, 0);
        s_rx = 0; s_ry = 0;
        step(0, 1, 0, 0);
        s_rx = W - 1; s_ry = H - 1;
        step(0, 1, 0, 0);
        idle(3);

        // Out-of-frame writes: discarded with clipping, passed through without.
        s_wx = W; s_wy = 0; s_wd = 4;
        step(0, 0, 1, 0);
        s_wx = 640; s_wy = 0; s_wd = 3;
        step(0, 0, 1, 0);
        s_wx = 2; s_wy = H; s_wd = 6;
        step(0, 0, 1, 0);
        idle(3);

        // Randomized traffic including occasional clears and resets.
        for (int i = 0; i < 2500; i++) begin
            bit r, rv, wv, cr;
            r  = ($urandom_range(399) == 0);
            rv = ($urandom_range(9) < 3);
            wv = ($urandom_range(1) == 1);
            cr = ($urandom_range(199) == 0);
            s_rx = $urandom_range(W + 1); s_ry = $urandom_range(H);
            s_wx = $urandom_range(W + 1); s_wy = $urandom_range(H);
            s_wd = $urandom_range(7);     s_cc = $urandom_range(7);
            step(r, rv, wv, cr);
        end

        // Let any active clear finish, then drain outstanding responses.
        for (int i = 0; m_clear && i < 4 * W * H; i++) step(0, 0, 0, 0);
        idle(6);
        @(negedge clk);
        #1;
        chk("clear_left_running", int'(m_clear), 0);
        chk("pending_writes", wq.size(), 0);
        chk("pending_reads", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_arbiter.md
FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 SHALL have parameter FRAME_W, default 640, frame width in pixels.
REQ-002 SHALL have parameter FRAME_H, default 480, frame height in pixels.
REQ-003 SHALL have parameter RD_LAT, default 1, frame memory read latency in cycles (1..3).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports clear_req in 1 (start clear pulse), clear_color in 3 (clear pixel value), clear_busy out 1, clear_done out 1 (one-cycle completion pulse).
REQ-007 SHALL have ports wr_valid in 1, wr_x in 10, wr_y in 9, wr_data in 3, wr_ready out 1 (pixel write request handshake).
REQ-008 SHALL have ports rd_valid in 1, rd_x in 10, rd_y in 9 (scanout read, never stalled), rd_data_valid out 1, rd_data out 3.
REQ-009 SHALL have memory-side ports mem_write_enable out 1, mem_write_width out 10, mem_write_height out 9, mem_write_data out 3, mem_read_width out 10, mem_read_height out 9, mem_read_data in 3.

Function
REQ-010 SHALL grant the frame memory to at most one access per cycle, fixed priority: read > clear > pixel write.
REQ-011 SHALL accept a read in every cycle rd_valid=1; memory-side outputs SHALL be registered, so rd_data_valid=1 exactly 1+RD_LAT cycles after the accepting cycle, rd_data=mem_read_data in that cycle.
REQ-012 SHALL drive mem_write_enable=0 in every cycle a read is issued to memory; read address SHALL be held at last value when no read is issued.
REQ-013 SHALL compute wr_ready combinationally = !rd_valid && state==IDLE; transfer occurs when wr_valid && wr_ready; write appears at memory one cycle later.
REQ-014 SHALL implement states IDLE and CLEAR; IDLE->CLEAR on clear_req=1 in IDLE; clear_req in CLEAR SHALL be ignored.
REQ-015 SHALL latch clear_color at the accepting clear_req; a write transferring in that same cycle SHALL complete normally.
REQ-016 SHALL in CLEAR write clear_color to (x,y) raster order, x inner 0..FRAME_W-1, y outer 0..FRAME_H-1, advancing only in cycles without rd_valid.
REQ-017 SHALL after the (FRAME_W-1, FRAME_H-1) write pulse clear_done for one cycle and return to IDLE in that cycle; clear_busy=1 exactly while state==CLEAR.
REQ-018 SHALL complete a clear in FRAME_W*FRAME_H plus number-of-read-cycles cycles (307200 with no reads at defaults).
REQ-019 SHALL hold wr_ready=0 for the whole of CLEAR.

Reset
REQ-020 SHALL on rst: state=IDLE, clear counters=0, clear_busy=0, clear_done=0, mem_write_enable=0, all memory addresses/data=0, rd_data_valid pipeline flushed to 0.
REQ-021 SHALL abort a clear in progress on rst with no clear_done pulse; reads in flight SHALL produce no rd_data_valid.
REQ-022 SHALL hold wr_ready=0 while rst=1.

Configuration
REQ-023 SHALL, with FRAME_ARBITER_CLIP_EN defined, accept a pixel write with wr_x>=FRAME_W or wr_y>=FRAME_H via normal handshake and discard it (mem_write_enable stays 0).
REQ-024 SHALL, without FRAME_ARBITER_CLIP_EN, pass all accepted writes to memory unchecked.

Structure
REQ-025 SHALL take FRAME_W/FRAME_H defaults, coordinate widths (10/9), 3-bit pixel typedef and IDLE/CLEAR state enum from shared package frame_pkg.
REQ-026 SHALL place the clear raster x/y counter with enable, wrap and last-pixel flag in sub-module frame_clear_counter.

Verification
REQ-027 Write (5,7,data 3), no reads -> wr_ready=1, next cycle mem_write_enable=1, width 5, height 7, data 3.
REQ-028 rd_valid and wr_valid both high for 4 cycles -> wr_ready=0 all 4, 4 reads issued, rd_data_valid high 2 cycles after each (RD_LAT=1), write lands in cycle after rd_valid drops.
REQ-029 clear_req with color 6, no reads -> 307200 writes of 6 in raster order, last at (639,479), clear_done single pulse, clear_busy falls with it.
REQ-030 Clear with rd_valid every 4th cycle -> clear counter frozen in read cycles, completion 307200+reads cycles, no lost/duplicate pixels.
REQ-031 rst at pixel (100,20) of clear -> outputs at reset values next cycle, no clear_done, new clear_req restarts at (0,0).
REQ-032 CLIP_EN defined, write (640,0) -> handshake completes, no memory write; undefined -> memory write to width 640.
